sample_feeder: RTL and testbench
================================

SAMPLE_FEEDER -- requirements
Module: sample_feeder

Interface
REQ-001 Parameter INPUT_WIDTH, default 3: width of one IF sample word.
REQ-002 Parameter ADDR_WIDTH, default 16: sample buffer address width.
REQ-003 Parameter HALF_PERIOD, default 4: clk cycles per clk_sample half-period; legal values are 2 or more.
REQ-004 Parameter HOLD_CYCLES, default 4: clk cycles that feed_reset and feed_complete are held high; legal values are 3 or more, which covers the receiver's 2-flop synchronizer.
REQ-005 Port clk, input, 1: the single clock; all outputs are registered on its rising edge.
REQ-006 Port global_reset, input, 1: reset; asynchronous, active-high.
REQ-007 Port start, input, 1: single-cycle request to play back one buffer.
REQ-008 Port abort, input, 1: terminate playback immediately.
REQ-009 Port num_samples, input, ADDR_WIDTH: number of samples to play; captured when start is accepted.
REQ-010 Port mem_addr, output, ADDR_WIDTH: sample buffer read address.
REQ-011 Port mem_data, input, INPUT_WIDTH: buffer read data; valid one clk cycle after mem_addr.
REQ-012 Port clk_sample, output, 1: generated sample clock; receiver samples on its rising edge.
REQ-013 Port sample_valid, output, 1: data holds a live sample.
REQ-014 Port feed_reset, output, 1: start-of-feed marker.
REQ-015 Port feed_complete, output, 1: end-of-feed marker.
REQ-016 Port data, output, INPUT_WIDTH: current sample.
REQ-017 Port busy, output, 1: high in every state except IDLE.
REQ-018 Port sample_count, output, ADDR_WIDTH: number of samples presented so far in this feed.

Function
REQ-019 The FSM SHALL have four states: IDLE, RESET_FEED, FEED and COMPLETE.
REQ-020 In IDLE, start=1 SHALL capture num_samples, clear sample_count and mem_addr, and enter RESET_FEED on the next cycle.
REQ-021 In every state except IDLE, start SHALL be ignored.
REQ-022 RESET_FEED SHALL hold feed_reset=1 for exactly HOLD_CYCLES cycles with clk_sample=0 and sample_valid=0, and SHALL present mem_addr=0.
REQ-023 On RESET_FEED exit with num_samples=0, the FSM SHALL enter COMPLETE; otherwise it SHALL enter FEED.
REQ-024 In the first FEED cycle, data SHALL be loaded with mem_data for address 0, sample_valid set to 1, and sample_count set to 1.
REQ-025 In FEED, each sample period SHALL be HALF_PERIOD cycles with clk_sample=0 followed by HALF_PERIOD cycles with clk_sample=1.
REQ-026 In FEED, data SHALL change only in the cycle clk_sample falls, so it is stable for HALF_PERIOD cycles before every rising edge.
REQ-027 mem_addr SHALL increment by 1 in the cycle clk_sample rises; the next sample SHALL be loaded into data, and sample_count incremented, at the following falling edge.
REQ-028 When clk_sample falls after sample num_samples-1, the block SHALL drive sample_valid=0, keep clk_sample=0, hold data at its last value, and enter COMPLETE.
REQ-029 COMPLETE SHALL hold feed_complete=1 for exactly HOLD_CYCLES cycles, then enter IDLE.
REQ-030 feed_reset and feed_complete SHALL never be high in the same cycle.
REQ-031 abort=1 in any non-IDLE state SHALL, on the next cycle, force IDLE with clk_sample=0, sample_valid=0, feed_reset=0 and feed_complete=0, and SHALL NOT pulse feed_complete.
REQ-032 When start and abort are both 1 in IDLE, abort SHALL win and the state SHALL remain IDLE.
REQ-033 sample_count SHALL hold its final value in IDLE until the next accepted start.
REQ-034 sample_count SHALL saturate at num_samples and never wrap; mem_addr SHALL never exceed num_samples-1.
REQ-035 num_samples = 2^ADDR_WIDTH-1 SHALL play all addresses 0 through 2^ADDR_WIDTH-2 without wrap.

Reset
REQ-036 When global_reset=1, the block SHALL asynchronously force state=IDLE and drive clk_sample, sample_valid, feed_reset, feed_complete and busy to 0, and data, mem_addr and sample_count to 0.
REQ-037 global_reset asserted mid-FEED SHALL take effect immediately and SHALL NOT emit feed_complete.
REQ-038 After global_reset is released, the block SHALL stay in IDLE until start is asserted.

Verification
REQ-039 Basic playback: defaults, num_samples=3, buffer={5,2,7}, start -> feed_reset high 4 cycles; data 5,2,7 each stable 4 cycles before a clk_sample rise; 3 rising edges with sample_valid=1; feed_complete high 4 cycles; sample_count=3; busy low afterward.
REQ-040 Empty feed: num_samples=0, start -> feed_reset high 4 cycles, then feed_complete high 4 cycles; no clk_sample edge; sample_valid never 1.
REQ-041 Abort: assert abort during the high half of sample 2 of 10 -> all feed outputs 0 the next cycle; no feed_complete pulse; sample_count=2; a new start is accepted afterward.
REQ-042 Reset mid-feed: assert global_reset asynchronously between clk edges -> outputs 0 before the next clk edge; after release, idle until start.
REQ-043 Ignored start: pulse start during FEED with a different num_samples -> no effect; the original length completes.
REQ-044 Timing corner: HALF_PERIOD=2, num_samples=4 -> period 4 cycles; each data change precedes its clk_sample rise by 2 cycles; mem_addr sequence 0,1,2,3; no address 4 is issued.

Source files
------------

// File: rtl/sample_feeder.sv
// Plays a sample buffer out to a receiver on a generated sample clock.
// The feed is framed by feed_reset and feed_complete marker pulses.
//
// state      | meaning
// IDLE       | waiting for start
// RESET_FEED | feed_reset held high, mem_addr parked at 0
// FEED       | clk_sample toggling, one sample per period
// COMPLETE   | feed_complete held high
module sample_feeder #(
  parameter int INPUT_WIDTH = 3,
  parameter int ADDR_WIDTH  = 16,
  parameter int HALF_PERIOD = 4,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   global_reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ADDR_WIDTH-1:0]  num_samples,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [INPUT_WIDTH-1:0] mem_data,
  output logic                   clk_sample,
  output logic                   sample_valid,
  output logic                   feed_reset,
  output logic                   feed_complete,
  output logic [INPUT_WIDTH-1:0] data,
  output logic                   busy,
  output logic [ADDR_WIDTH-1:0]  sample_count
);

  localparam int HOLD_W  = $clog2(HOLD_CYCLES);
  localparam int PHASE_W = $clog2(HALF_PERIOD);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_RESET_FEED = 2'd1,
    S_FEED       = 2'd2,
    S_COMPLETE   = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [PHASE_W-1:0]     phase_q, phase_d;
  logic [ADDR_WIDTH-1:0]  num_q, num_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]  count_q, count_d;
  logic [INPUT_WIDTH-1:0] data_q, data_d;
  logic                   clk_s_q, clk_s_d;
  logic                   valid_q, valid_d;
  logic                   frst_q, frst_d;
  logic                   fcmp_q, fcmp_d;
  logic                   busy_q, busy_d;

  always_ff @(posedge clk or posedge global_reset) begin
    if (global_reset) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      phase_q <= '0;
      num_q   <= '0;
      addr_q  <= '0;
      count_q <= '0;
      data_q  <= '0;
      clk_s_q <= 1'b0;
      valid_q <= 1'b0;
      frst_q  <= 1'b0;
      fcmp_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      phase_q <= phase_d;
      num_q   <= num_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      data_q  <= data_d;
      clk_s_q <= clk_s_d;
      valid_q <= valid_d;
      frst_q  <= frst_d;
      fcmp_q  <= fcmp_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    phase_d = phase_q;
    num_d   = num_q;
    addr_d  = addr_q;
    count_d = count_q;
    data_d  = data_q;
    clk_s_d = clk_s_q;
    valid_d = valid_q;
    frst_d  = frst_q;
    fcmp_d  = fcmp_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_RESET_FEED;
          num_d   = num_samples;
          count_d = '0;
          addr_d  = '0;
          frst_d  = 1'b1;
          hold_d  = HOLD_W'(HOLD_CYCLES - 1);
        end
      end
      S_RESET_FEED: begin
        if (hold_q == '0) begin
          frst_d = 1'b0;
          if (num_q == '0) begin
            state_d = S_COMPLETE;
            fcmp_d  = 1'b1;
            hold_d  = HOLD_W'(HOLD_CYCLES - 1);
          end else begin
            state_d = S_FEED;
            data_d  = mem_data;
            valid_d = 1'b1;
            count_d = ADDR_WIDTH'(1);
            clk_s_d = 1'b0;
            phase_d = PHASE_W'(HALF_PERIOD - 1);
          end
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      S_FEED: begin
        if (phase_q != '0) begin
          phase_d = phase_q - PHASE_W'(1);
        end else if (!clk_s_q) begin
          // Prefetch the next address on the rise so mem_data settles before the fall.
          clk_s_d = 1'b1;
          phase_d = PHASE_W'(HALF_PERIOD - 1);
          if (count_q != num_q) addr_d = addr_q + ADDR_WIDTH'(1);
        end else if (count_q == num_q) begin
          state_d = S_COMPLETE;
          clk_s_d = 1'b0;
          valid_d = 1'b0;
          fcmp_d  = 1'b1;
          hold_d  = HOLD_W'(HOLD_CYCLES - 1);
        end else begin
          clk_s_d = 1'b0;
          data_d  = mem_data;
          count_d = count_q + ADDR_WIDTH'(1);
          phase_d = PHASE_W'(HALF_PERIOD - 1);
        end
      end
      S_COMPLETE: begin
        if (hold_q == '0) begin
          state_d = S_IDLE;
          fcmp_d  = 1'b0;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort freezes data, address and count where they stand.
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      addr_d  = addr_q;
      count_d = count_q;
      data_d  = data_q;
      clk_s_d = 1'b0;
      valid_d = 1'b0;
      frst_d  = 1'b0;
      fcmp_d  = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  assign mem_addr      = addr_q;
  assign sample_count  = count_q;
  assign data          = data_q;
  assign clk_sample    = clk_s_q;
  assign sample_valid  = valid_q;
  assign feed_reset    = frst_q;
  assign feed_complete = fcmp_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_sample_feeder.sv
// Randomized bench for sample_feeder: two instances (default and a small fast one)
// checked cycle by cycle against a timeline model of a feed.
module tb_sample_feeder;

  localparam int P0 = 4, H0 = 4;
  localparam int P1 = 2, H1 = 3;

  typedef struct {
    logic        ck, vl, fr, fc, by;
    logic [2:0]  dt;
    logic [15:0] ad, ct;
  } exp_t;

  logic        clk = 1'b0;
  logic        global_reset;
  logic        start, abort, sel;
  logic [15:0] num;

  logic [15:0] addr0, cnt0;
  logic [2:0]  mdat0, dat0;
  logic        cks0, vl0, fr0, fc0, by0;
  logic [3:0]  addr1, cnt1;
  logic [2:0]  mdat1, dat1;
  logic        cks1, vl1, fr1, fc1, by1;

  logic [2:0]  buffer [0:65535];
  logic [2:0]  last_data [2];
  int          last_count [2];
  int          n_err = 0, n_checks = 0, cur_k = 0;

  always #5 clk = ~clk;

  sample_feeder dut0 (
    .clk(clk), .global_reset(global_reset), .start(start & ~sel), .abort(abort & ~sel),
    .num_samples(num), .mem_addr(addr0), .mem_data(mdat0), .clk_sample(cks0),
    .sample_valid(vl0), .feed_reset(fr0), .feed_complete(fc0), .data(dat0),
    .busy(by0), .sample_count(cnt0));

  sample_feeder #(.INPUT_WIDTH(3), .ADDR_WIDTH(4), .HALF_PERIOD(P1), .HOLD_CYCLES(H1)) dut1 (
    .clk(clk), .global_reset(global_reset), .start(start & sel), .abort(abort & sel),
    .num_samples(num[3:0]), .mem_addr(addr1), .mem_data(mdat1), .clk_sample(cks1),
    .sample_valid(vl1), .feed_reset(fr1), .feed_complete(fc1), .data(dat1),
    .busy(by1), .sample_count(cnt1));

  always @(posedge clk) begin
    mdat0 <= buffer[addr0];
    mdat1 <= buffer[addr1];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s k=%0d sel=%0d: got %0h expected %0h", tag, cur_k, sel, obs, exp);
    end
  endtask

  task automatic chk_all(input exp_t e);
    if (sel) begin
      chk("clk_sample", 32'(cks1), 32'(e.ck));
      chk("sample_valid", 32'(vl1), 32'(e.vl));
      chk("feed_reset", 32'(fr1), 32'(e.fr));
      chk("feed_complete", 32'(fc1), 32'(e.fc));
      chk("busy", 32'(by1), 32'(e.by));
      chk("data", 32'(dat1), 32'(e.dt));
      chk("mem_addr", 32'(addr1), 32'(e.ad));
      chk("sample_count", 32'(cnt1), 32'(e.ct));
    end else begin
      chk("clk_sample", 32'(cks0), 32'(e.ck));
      chk("sample_valid", 32'(vl0), 32'(e.vl));
      chk("feed_reset", 32'(fr0), 32'(e.fr));
      chk("feed_complete", 32'(fc0), 32'(e.fc));
      chk("busy", 32'(by0), 32'(e.by));
      chk("data", 32'(dat0), 32'(e.dt));
      chk("mem_addr", 32'(addr0), 32'(e.ad));
      chk("sample_count", 32'(cnt0), 32'(e.ct));
    end
  endtask

  function automatic exp_t zero_e();
    exp_t e;
    e.ck = 0; e.vl = 0; e.fr = 0; e.fc = 0; e.by = 0;
    e.dt = '0; e.ad = '0; e.ct = '0;
    return e;
  endfunction

  // Expected outputs k cycles after the accepting edge of a feed of n samples.
  function automatic exp_t model(int k, int n, int p, int h, logic [2:0] ld);
    exp_t e;
    int fs, o, i, r;
    e = zero_e();
    e.dt = ld; e.by = 1;
    fs = h + 1 + ((n > 0) ? 2 * p * n : 0);
    if (k <= h) begin
      e.fr = 1;
    end else if (k < fs) begin
      o = k - h - 1; i = o / (2 * p); r = o % (2 * p);
      e.ck = (r >= p); e.vl = 1;
      e.dt = buffer[i]; e.ct = 16'(i + 1);
      e.ad = (r < p) ? 16'(i) : ((i + 1 < n) ? 16'(i + 1) : 16'(n - 1));
    end else begin
      if (n > 0) begin
        e.dt = buffer[n-1]; e.ct = 16'(n); e.ad = 16'(n - 1);
      end
      if (k < fs + h) e.fc = 1;
      else e.by = 0;
    end
    return e;
  endfunction

  // ka: abort cycle, ks: ignored-start cycle, kr: async-reset cycle (0 = none).
  task automatic run(input int s, input int n, input int ka, input int ks, input int kr, input bit rnd);
    int p, h, total;
    bit aborted;
    exp_t e, hold_e;
    p = s ? P1 : P0;
    h = s ? H1 : H0;
    aborted = 0;
    hold_e = zero_e();
    if (rnd) for (int i = 0; i < n; i++) buffer[i] = 3'($urandom_range(0, 7));
    total = h + ((n > 0) ? 2 * p * n : 0) + h + 3;
    sel = s[0]; start = 1; num = 16'(n);
    @(posedge clk); #1;
    start = 0; num = 16'($urandom);
    for (int k = 1; k <= total; k++) begin
      cur_k = k;
      e = aborted ? hold_e : model(k, n, p, h, last_data[s]);
      chk_all(e);
      if (k == kr) begin
        #3 global_reset = 1;
        #1 chk_all(zero_e());
        last_data[0] = '0; last_data[1] = '0;
        last_count[0] = 0; last_count[1] = 0;
        @(posedge clk); #2 global_reset = 0;
        for (int j = 0; j < 4; j++) begin
          @(posedge clk); #1 chk_all(zero_e());
        end
        return;
      end
      abort = 0;
      if (k == ka) begin
        abort = 1; aborted = 1;
        hold_e = e;
        hold_e.ck = 0; hold_e.vl = 0; hold_e.fr = 0; hold_e.fc = 0; hold_e.by = 0;
      end
      start = (k == ks);
      if (k == ks) num = 16'(n + 3);
      @(posedge clk); #1;
    end
    abort = 0; start = 0;
    if (aborted) begin
      last_data[s] = hold_e.dt; last_count[s] = int'(hold_e.ct);
    end else begin
      if (n > 0) last_data[s] = buffer[n-1];
      last_count[s] = n;
    end
  endtask

  initial begin
    int s, n, ka, p, h;
    global_reset = 1; start = 0; abort = 0; num = '0; sel = 0;
    last_data[0] = '0; last_data[1] = '0; last_count[0] = 0; last_count[1] = 0;
    @(posedge clk); #1;
    chk_all(zero_e());
    sel = 1; chk_all(zero_e()); sel = 0;
    @(negedge clk); global_reset = 0;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1 chk_all(zero_e());
    end

    // start and abort together in IDLE: abort wins
    start = 1; abort = 1; num = 16'd3;
    @(posedge clk); #1; start = 0; abort = 0;
    chk_all(zero_e());
    @(posedge clk); #1 chk_all(zero_e());

    buffer[0] = 3'd5; buffer[1] = 3'd2; buffer[2] = 3'd7;
    run(0, 3, 0, 0, 0, 0);
    run(0, 0, 0, 0, 0, 1);
    run(0, 10, H0 + 1 + 2 * P0 + P0, 0, 0, 1);
    chk("abort_count", 32'(cnt0), 32'd2);
    run(0, 5, 0, 10, 0, 1);
    run(0, 6, 0, 0, H0 + 1 + 4 * P0 + 1, 1);
    run(0, 2, 0, 0, 0, 1);
    run(1, 4, 0, 0, 0, 1);
    run(1, 15, 0, 0, 0, 1);
    run(1, 0, 0, 0, 0, 1);

    for (int it = 0; it < 8; it++) begin
      s = int'($urandom_range(0, 1));
      n = s ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 12));
      p = s ? P1 : P0;
      h = s ? H1 : H0;
      ka = 0;
      if (n > 0 && $urandom_range(0, 2) == 0) ka = int'($urandom_range(h + 1, h + 2 * p * n));
      run(s, n, ka, 0, 0, 1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
